// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state encodings and helpers for the d16 control sequencer
package cpu_sequencer_pkg;

  // 4-bit encodings are fixed so debug and formal code can decode the state register.
  typedef enum logic [3:0] {
    SEQ_IDLE    = 4'd0,
    SEQ_FETCH   = 4'd1,
    SEQ_DECODE  = 4'd2,
    SEQ_REGREAD = 4'd3,
    SEQ_IMM     = 4'd4,
    SEQ_ALU     = 4'd5,
    SEQ_MEM     = 4'd6,
    SEQ_WB      = 4'd7,
    SEQ_FAULT   = 4'd8
  } seq_state_e;

  function automatic logic is_req_state(input seq_state_e s);
    return (s == SEQ_FETCH) || (s == SEQ_IMM) || (s == SEQ_MEM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unacknowledged memory request cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 2);

  logic [CW-1:0] cnt_q;

  // expired means this request cycle is the (MEM_TIMEOUT-1)th without an ack.
  assign expired = (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the d16 core
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             next_word,
  input  logic             en_mem,
  input  logic             is_store,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             dec_en,
  output logic             instr_latch,
  output logic             imm_latch,
  output logic             pc_inc,
  output logic             en_regread,
  output logic             en_alu,
  output logic             en_regwrite,
  output logic             busy,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_e state_q, state_d;
  logic       req_state;
  logic       wait_expired;

  assign req_state = is_req_state(state_q);

  // The counter idles at zero outside request states, so it is clear on every entry.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!req_state),
    .count   (req_state && !mem_ack),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == SEQ_FAULT) bus_err <= 1'b1;
      if (state_q == SEQ_WB) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    dec_en       = 1'b0;
    instr_latch  = 1'b0;
    imm_latch    = 1'b0;
    pc_inc       = 1'b0;
    en_regread   = 1'b0;
    en_alu       = 1'b0;
    en_regwrite  = 1'b0;
    busy         = 1'b1;
    case (state_q)
      SEQ_IDLE: begin
        busy = 1'b0;
        if (run) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          instr_latch = 1'b1;
          pc_inc      = 1'b1;
          state_d     = SEQ_DECODE;
        end else if (wait_expired) begin
          state_d = SEQ_FAULT;
        end
      end
      SEQ_DECODE: begin
        dec_en  = 1'b1;
        state_d = SEQ_REGREAD;
      end
      SEQ_REGREAD: begin
        en_regread = 1'b1;
        state_d    = next_word ? SEQ_IMM : SEQ_ALU;
      end
      SEQ_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_latch = 1'b1;
          pc_inc    = 1'b1;
          state_d   = SEQ_ALU;
        end else if (wait_expired) begin
          state_d = SEQ_FAULT;
        end
      end
      SEQ_ALU: begin
        en_alu  = 1'b1;
        state_d = en_mem ? SEQ_MEM : SEQ_WB;
      end
      SEQ_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ack) begin
          state_d = SEQ_WB;
        end else if (wait_expired) begin
          state_d = SEQ_FAULT;
        end
      end
      SEQ_WB: begin
        en_regwrite = 1'b1;
        state_d     = run ? SEQ_FETCH : SEQ_IDLE;
      end
      SEQ_FAULT: begin
        busy = 1'b0;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer driven by hand-computed per-cycle vectors
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 6;
  localparam int CNT_W       = 16;

  // Output vector: {busy, bus_err, mem_req, mem_we, mem_addr_sel, dec_en,
  //                 instr_latch, imm_latch, pc_inc, en_regread, en_alu, en_regwrite}
  localparam logic [11:0] O_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] O_FW    = 12'b1010_0000_0000;
  localparam logic [11:0] O_FA    = 12'b1010_0010_1000;
  localparam logic [11:0] O_DEC   = 12'b1000_0100_0000;
  localparam logic [11:0] O_RR    = 12'b1000_0000_0100;
  localparam logic [11:0] O_IW    = 12'b1010_0000_0000;
  localparam logic [11:0] O_IA    = 12'b1010_0001_1000;
  localparam logic [11:0] O_ALU   = 12'b1000_0000_0010;
  localparam logic [11:0] O_MLD   = 12'b1010_1000_0000;
  localparam logic [11:0] O_MST   = 12'b1011_1000_0000;
  localparam logic [11:0] O_WB    = 12'b1000_0000_0001;
  localparam logic [11:0] O_FAULT = 12'b0100_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0, next_word = 1'b0, en_mem = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, dec_en, instr_latch, imm_latch, pc_inc;
  logic             en_regread, en_alu, en_regwrite, busy, bus_err;
  logic [CNT_W-1:0] instr_count;

  cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .next_word(next_word), .en_mem(en_mem),
    .is_store(is_store), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .dec_en(dec_en), .instr_latch(instr_latch),
    .imm_latch(imm_latch), .pc_inc(pc_inc), .en_regread(en_regread), .en_alu(en_alu),
    .en_regwrite(en_regwrite), .busy(busy), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]      o;
    logic [CNT_W-1:0] c;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad = 0;
  int               step_no = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e = sb.pop_front();
      act = {busy, bus_err, mem_req, mem_we, mem_addr_sel, dec_en,
             instr_latch, imm_latch, pc_inc, en_regread, en_alu, en_regwrite};
      total++;
      if (act !== e.o) begin
        bad++;
        $display("FAIL %s outputs: got %b want %b", e.tag, act, e.o);
      end
      total++;
      if (instr_count !== e.c) begin
        bad++;
        $display("FAIL %s instr_count: got %0d want %0d", e.tag, instr_count, e.c);
      end
    end
  end

  // One cycle: drive inputs shortly after the edge, queue the expected response.
  task automatic step(input string tag, input logic r, input logic nw, input logic em,
                      input logic st, input logic ack, input logic [11:0] o,
                      input logic rst = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    run = r; next_word = nw; en_mem = em; is_store = st; mem_ack = ack;
    #1;
    rst_n = !rst;
    if (rst) exp_cnt = '0;
    step_no++;
    e.o = o;
    e.c = exp_cnt;
    e.tag = $sformatf("%s#%0d", tag, step_no);
    sb.push_back(e);
    if (o == O_WB && !rst) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    step("reset", 0, 0, 0, 0, 0, O_IDLE, 1'b1);
    step("idle_hold", 0, 0, 0, 0, 1, O_IDLE);
    // ADD: F D R A W
    step("add_idle", 1, 0, 0, 0, 0, O_IDLE);
    step("add_f", 1, 0, 0, 0, 1, O_FA);
    step("add_d", 1, 0, 0, 0, 0, O_DEC);
    step("add_r", 1, 0, 0, 0, 0, O_RR);
    step("add_a", 1, 0, 0, 0, 0, O_ALU);
    step("add_w", 1, 0, 0, 0, 0, O_WB);
    // ADDI: immediate word fetched
    step("addi_f", 1, 0, 0, 0, 1, O_FA);
    step("addi_d", 1, 0, 0, 0, 0, O_DEC);
    step("addi_r", 1, 1, 0, 0, 0, O_RR);
    step("addi_i", 1, 0, 0, 0, 1, O_IA);
    step("addi_a", 1, 0, 0, 0, 0, O_ALU);
    step("addi_w", 1, 0, 0, 0, 0, O_WB);
    // ST with three wait cycles; stray ack in DECODE is ignored
    step("st_f", 1, 0, 0, 0, 1, O_FA);
    step("st_d", 1, 0, 0, 0, 1, O_DEC);
    step("st_r", 1, 0, 0, 0, 0, O_RR);
    step("st_a", 1, 0, 1, 0, 0, O_ALU);
    step("st_m0", 1, 0, 0, 1, 0, O_MST);
    step("st_m1", 1, 0, 0, 1, 0, O_MST);
    step("st_m2", 1, 0, 0, 1, 0, O_MST);
    step("st_m3", 1, 0, 0, 1, 1, O_MST);
    step("st_w", 1, 0, 0, 0, 0, O_WB);
    // LD, then run dropped in ALU: completes WB and parks in IDLE
    step("ld_f", 1, 0, 0, 0, 1, O_FA);
    step("ld_d", 1, 0, 0, 0, 0, O_DEC);
    step("ld_r", 1, 0, 0, 0, 0, O_RR);
    step("ld_a", 0, 0, 1, 0, 0, O_ALU);
    step("ld_m", 0, 0, 0, 0, 1, O_MLD);
    step("ld_w", 0, 0, 0, 0, 0, O_WB);
    step("stop_idle", 0, 0, 0, 0, 0, O_IDLE);
    step("stop_idle2", 0, 0, 0, 0, 1, O_IDLE);
    // reset asserted mid-IMM wait
    step("rst_idle", 1, 0, 0, 0, 0, O_IDLE);
    step("rst_f", 1, 0, 0, 0, 1, O_FA);
    step("rst_d", 1, 0, 0, 0, 0, O_DEC);
    step("rst_r", 1, 1, 0, 0, 0, O_RR);
    step("rst_iw", 1, 0, 0, 0, 0, O_IW);
    step("rst_hit", 1, 0, 0, 0, 0, O_IDLE, 1'b1);
    step("rst_rel", 0, 0, 0, 0, 0, O_IDLE);
    // ack on the last allowed wait cycle wins
    step("lim_idle", 1, 0, 0, 0, 0, O_IDLE);
    for (int i = 0; i < MEM_TIMEOUT - 2; i++) step("lim_fw", 1, 0, 0, 0, 0, O_FW);
    step("lim_fa", 1, 0, 0, 0, 1, O_FA);
    step("lim_d", 1, 0, 0, 0, 0, O_DEC);
    step("lim_r", 1, 0, 0, 0, 0, O_RR);
    step("lim_a", 1, 0, 0, 0, 0, O_ALU);
    step("lim_w", 1, 0, 0, 0, 0, O_WB);
    // no ack: fault after MEM_TIMEOUT-1 request cycles, sticky until reset
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("to_fw", 1, 0, 0, 0, 0, O_FW);
    step("fault0", 1, 1, 1, 1, 1, O_FAULT);
    step("fault1", 1, 0, 0, 0, 1, O_FAULT);
    step("fault_rst", 1, 0, 0, 0, 0, O_IDLE, 1'b1);
    step("post_rst", 0, 0, 0, 0, 0, O_IDLE);
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
